// File: rtl/jt49_dcrm_avg_if.sv
// Sample-stream bundle for the DC-removal averager: live/delayed samples in, corrected sample and mean out.
interface jt49_dcrm_avg_if #(
   parameter int dw = 8
);
   logic                 cen;
   logic                 clr;
   logic [dw-1:0]        din;
   logic [dw-1:0]        dly_din;
   logic signed [dw:0]   dout;
   logic [dw-1:0]        avg;
   logic                 ready;
   logic                 err;

   modport master (
      output cen, clr, din, dly_din,
      input  dout, avg, ready, err
   );

   modport slave (
      input  cen, clr, din, dly_din,
      output dout, avg, ready, err
   );
endinterface

// File: rtl/jt49_dcrm_avg.sv
// Running-window DC removal: dout = din - mean of the last 2**depth samples.
// Optional macro JT49_DCRM_ERR_EN adds a sticky accumulator-underflow flag with clamping.
module jt49_dcrm_avg #(
   parameter int dw    = 8,
   parameter int depth = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   jt49_dcrm_avg_if.slave   bus
);
   localparam int AW = dw + depth;
   localparam logic [depth-1:0] CNT_LAST = '1;

   typedef enum logic {FILL, RUN} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [depth-1:0]    cnt_q, cnt_d;
   logic signed [dw:0]  dout_q, dout_d;
   logic [dw-1:0]       avg_q, avg_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;

   function automatic logic [dw-1:0] mean(input logic [AW-1:0] a);
      return dw'(a >> depth);
   endfunction

   // Both operands are unsigned dw-bit values, so dw+1 signed bits never overflow.
   function automatic logic signed [dw:0] sub(input logic [dw-1:0] a, input logic [dw-1:0] b);
      return $signed({1'b0, a}) - $signed({1'b0, b});
   endfunction

`ifdef JT49_DCRM_ERR_EN
   logic [AW:0] acc_add;
   assign acc_add = {1'b0, acc_q} + (AW+1)'(bus.din);
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      avg_d   = avg_q;
      err_d   = err_q;
      if (bus.clr) begin
         state_d = FILL;
         acc_d   = '0;
         cnt_d   = '0;
         dout_d  = '0;
         avg_d   = '0;
      end else if (bus.cen) begin
         if (state_q == FILL) begin
            // Delay line content is not valid yet, so dly_din is ignored while filling.
            acc_d  = acc_q + AW'(bus.din);
            cnt_d  = cnt_q + 1'b1;
            dout_d = '0;
            if (cnt_q == CNT_LAST) state_d = RUN;
         end else begin
            dout_d = sub(bus.din, mean(acc_q));
`ifdef JT49_DCRM_ERR_EN
            if (acc_add < (AW+1)'(bus.dly_din)) begin
               err_d = 1'b1;
               acc_d = '0;
            end else begin
               acc_d = AW'(acc_add - (AW+1)'(bus.dly_din));
            end
`else
            acc_d = acc_q + AW'(bus.din) - AW'(bus.dly_din);
`endif
         end
         avg_d = mean(acc_d);
      end
`ifndef JT49_DCRM_ERR_EN
      err_d = 1'b0;
`endif
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         acc_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         avg_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         avg_q   <= avg_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign bus.dout  = dout_q;
   assign bus.avg   = avg_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;
endmodule

// File: doc/jt49_dcrm_avg.md
# jt49_dcrm_avg

DC-removal averaging stage for the PSG audio filter chain. Sits directly downstream of the long delay line: it takes the live PSG sample and the same sample delayed by one full window, keeps a running window sum, and outputs the live sample minus the window mean. It removes the DC offset of the unsigned PSG mix before the next filter stage.

## Interface
- `dw`, 8: sample width of `din`/`dly_din` (unsigned).
- `depth`, 10: log2 of the averaging window W = 2**depth; must equal the delay line's depth.

- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cen`  in  1  sample-rate clock enable; state advances only when high.
- `clr`  in  1  synchronous restart of averaging, sampled on every `clk` edge.
- `din`  in  dw  live unsigned sample.
- `dly_din`  in  dw  delayed sample; at cen tick n equals `din` of cen tick n−W.
- `dout`  out  dw+1  signed `din` − mean, registered.
- `avg`  out  dw  current window mean, acc >> depth, registered.
- `ready`  out  1  high once the window is full (state RUN).
- `err`  out  1  sticky accumulator-underflow flag (see Configuration).

## Operation
- Accumulator `acc`: unsigned, dw+depth bits; fill counter `cnt`: depth bits.
- States: FILL (after reset/`clr`), RUN.
- FILL, on cen: acc ← acc + din; `dly_din` ignored (delay RAM content not yet valid); cnt ← cnt+1; `dout` ← 0. On the cen tick where cnt == W−1: cnt wraps to 0, state → RUN.
- RUN, on cen: acc ← acc + din − dly_din; `dout` ← din − (acc_old >> depth), using the pre-update acc; cnt holds.
- `avg` ← (acc_new >> depth) on every cen tick, in both states.
- Subtraction for `dout` is done at dw+1 bits signed; range −(2**dw−1)..+(2**dw−1); no saturation needed.
- `ready` is a registered copy of (state == RUN).
- `clr` high on a `clk` edge: acc, cnt, `dout`, `avg` ← 0; state → FILL; `err` unaffected. `clr` overrides a coincident cen; that sample is discarded.
- `cen` low: all registers hold, including across `clr`-free cycles.
- Accumulator width guarantees no overflow when `dly_din` is correctly aligned; misalignment is the only underflow source.

## Timing
- Reset (`rst_n` low, async): acc=0, cnt=0, state=FILL, `dout`=0, `avg`=0, `ready`=0, `err`=0. Deassertion is taken synchronously by the integrator; the first cen after release is FILL tick 0.
- Latency: `din` on cen tick n is reflected in `dout`/`avg` after the clk edge of tick n (1 cen).
- `ready` rises on the clk edge of FILL tick W−1, i.e. after W cen ticks. The first non-forced `dout` is produced on the next cen tick.
- Reset or `clr` mid-RUN: outputs are cleared in that cycle; a full W-tick refill is required before `ready`.

## Configuration
- `JT49_DCRM_ERR_EN` defined: in RUN, if acc + din < dly_din on a cen tick, `err` ← 1 (sticky until `rst_n`) and acc ← 0 (clamped) instead of wrapping.
- Not defined: no compare logic; `err` is tied to 0; acc wraps modulo 2**(dw+depth).

## Test plan
- dw=8, depth=4 (W=16); constant din=100, bench delay model exact. Required: `dout`=0 and `ready`=0 for ticks 0–15. `ready`=1 after tick 15 with `avg`=100. Thereafter `dout`=0 every tick.
- After fill at 100, step din to 200. Required: first tick `dout`=+100 with `avg`=106; second tick `dout`=+94. `avg` reaches 200 after 16 ticks, with `dout`=0 from then on.
- Hold cen low for 50 clk with din toggling. Required: all outputs and `ready` remain unchanged.
- In RUN, assert `clr` on the same edge as cen with din=255. Required: `dout`=0, `avg`=0, `ready`=0 next cycle; the next 16 cen ticks refill the window and `ready` returns.
- Pulse `rst_n` low mid-RUN, between clk edges. Required: all outputs go 0 immediately, without waiting for a clock edge.
- Macro defined; after fill at din=0, drive dly_din=255. Required: `err`=1 and acc=0 on that tick; `err` stays 1 through a `clr`. Same stimulus without the macro: `err`=0 and acc wraps to 2**12−255.
